// File: rtl/prince_ctr_stage.sv
// prince_ctr_stage
//   Counter-mode wrapper around the combinational PRINCE core. Holds the key and
//   the counter block and feeds both to the core. The core output is used as
//   keystream: each accepted input word is XORed with it and the result is
//   registered in a one-entry output buffer. Throughput is one word per cycle,
//   with one cycle of latency.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   cfg_valid/ready, cfg_key,  key/IV load handshake (IDLE or WRAP only)
//   cfg_iv
//   in_valid/ready, in_data,   input word stream
//   in_last
//   out_valid/ready, out_data, output word stream (in_data ^ keystream)
//   out_last
//   core_data_in, core_key,    to prince_core (counter, key, encrypt mode)
//   core_mode
//   core_data_out              from prince_core (keystream, combinational)
//   ctr_wrap_err               sticky flag: counter field ran out
module prince_ctr_stage #(
  parameter int TEXT_SIZE = 64,
  parameter int KEY_SIZE  = 128,
  parameter int CTR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [KEY_SIZE-1:0]  cfg_key,
  input  logic [TEXT_SIZE-1:0] cfg_iv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TEXT_SIZE-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TEXT_SIZE-1:0] out_data,
  output logic                 out_last,
  output logic [TEXT_SIZE-1:0] core_data_in,
  output logic [KEY_SIZE-1:0]  core_key,
  output logic                 core_mode,
  input  logic [TEXT_SIZE-1:0] core_data_out,
  output logic                 ctr_wrap_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, WRAP} state_t;

  // Mask of the incrementing counter field; built one bit wider so that
  // CTR_WIDTH == TEXT_SIZE still yields an all-ones mask.
  localparam logic [TEXT_SIZE:0]   CTR_SPAN = (TEXT_SIZE+1)'(1) << CTR_WIDTH;
  localparam logic [TEXT_SIZE-1:0] ONE      = TEXT_SIZE'(1);
  localparam logic [TEXT_SIZE-1:0] CTR_MASK = CTR_SPAN[TEXT_SIZE-1:0] - ONE;

  state_t               state;
  logic [KEY_SIZE-1:0]  key_q;
  logic [TEXT_SIZE-1:0] ctr_q;
  logic [TEXT_SIZE-1:0] ctr_inc;
  logic                 low_full;
  logic                 in_fire, out_fire, cfg_fire;

  assign core_data_in = ctr_q;
  assign core_key     = key_q;
  assign core_mode    = 1'b0;

  // Only the low field advances; the nonce part is held.
  assign ctr_inc  = (ctr_q & ~CTR_MASK) | ((ctr_q + ONE) & CTR_MASK);
  assign low_full = (ctr_q & CTR_MASK) == CTR_MASK;

  // A new key/IV only loads once the last output has left, so a pending word
  // never mixes with the next session.
  assign cfg_ready = ((state == IDLE) || (state == WRAP)) && !out_valid;
  // One-entry output register: accept when empty or emptying this cycle.
  assign in_ready  = (state == RUN) && (!out_valid || out_ready);

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      key_q        <= '0;
      ctr_q        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      ctr_wrap_err <= 1'b0;
    end else begin
      if (out_fire && !in_fire) out_valid <= 1'b0;

      if (in_fire) begin
        out_data  <= in_data ^ core_data_out;
        out_last  <= in_last;
        out_valid <= 1'b1;
        ctr_q     <= ctr_inc;
      end

      unique case (state)
        IDLE, WRAP: begin
          if (cfg_fire) begin
            key_q        <= cfg_key;
            ctr_q        <= cfg_iv;
            ctr_wrap_err <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            // A last word that wraps ends the message cleanly: no reuse
            // can follow it.
            if (in_last) begin
              state <= DRAIN;
            end else if (low_full) begin
              state        <= WRAP;
              ctr_wrap_err <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
